// File: rtl/uart_receiver.sv
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receive path, LSB first. Resynchronises the serial
//                line, detects the start edge, majority-votes three mid-bit
//                samples per bit and reports each byte with a one-clk valid
//                pulse, or a one-clk frame-error pulse on a bad stop bit.
//  Ports       : clk         - system clock
//                rst_n       - asynchronous active-low reset
//                clk_16_i    - one-clk enable pulse at 16x baud
//                rxd_i       - asynchronous serial input, idles high
//                rxd_data_o  - last correctly framed byte
//                rxd_flag_o  - one-clk pulse, rxd_data_o just updated
//                frame_err_o - one-clk pulse, stop bit sampled low
//                busy_o      - high while a frame is being received
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver #(
    parameter logic [3:0] SMP_TOP = 4'd15,
    parameter logic [3:0] SMP_MID = 4'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_16_i,
    input  logic       rxd_i,
    output logic [7:0] rxd_data_o,
    output logic       rxd_flag_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } state_t;

    localparam logic [3:0] C_SMP_LO = SMP_MID - 4'd1;
    localparam logic [3:0] C_SMP_HI = SMP_MID + 4'd1;

    // Line synchroniser and edge-detect delay flop
    logic       r_meta;
    logic       r_sync;
    logic       r_dly;
    logic       w_fall;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_smp_cnt;
    logic [3:0] w_smp_cnt_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [2:0] r_smp;
    logic [2:0] w_smp_nxt;
    logic [7:0] w_data_nxt;
    logic       w_flag_nxt;
    logic       w_err_nxt;
    logic       w_s2;
    logic       w_vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_dly  <= 1'b1;
        end else begin
            r_meta <= rxd_i;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign w_fall = r_dly & ~r_sync;

    // On the last vote tick the third sample is still on the line, so it is
    // folded in directly; that lets decisions be made on that very tick.
    assign w_s2   = (r_smp_cnt == C_SMP_HI) ? r_sync : r_smp[2];
    assign w_vote = (r_smp[0] & r_smp[1]) | (r_smp[1] & w_s2) | (r_smp[0] & w_s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            r_smp_cnt   <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_smp       <= 3'b000;
            rxd_data_o  <= 8'h00;
            rxd_flag_o  <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_smp_cnt   <= w_smp_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_smp       <= w_smp_nxt;
            rxd_data_o  <= w_data_nxt;
            rxd_flag_o  <= w_flag_nxt;
            frame_err_o <= w_err_nxt;
            busy_o      <= (w_state_nxt != R_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_smp_cnt_nxt = r_smp_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_smp_nxt     = r_smp;
        w_data_nxt    = rxd_data_o;
        w_flag_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        if (r_state == R_IDLE) begin
            // Edge detection runs every clk, not only on ticks
            if (w_fall) begin
                w_state_nxt = R_START;
            end
        end else if (clk_16_i) begin
            w_smp_cnt_nxt = r_smp_cnt + 4'd1;

            if (r_smp_cnt == C_SMP_LO) w_smp_nxt[0] = r_sync;
            if (r_smp_cnt == SMP_MID)  w_smp_nxt[1] = r_sync;
            if (r_smp_cnt == C_SMP_HI) w_smp_nxt[2] = r_sync;

            case (r_state)
                R_START: begin
                    if ((r_smp_cnt == C_SMP_HI) && w_vote) begin
                        w_state_nxt = R_IDLE;          // false start
                    end else if (r_smp_cnt == SMP_TOP) begin
                        w_state_nxt   = R_DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
                R_DATA: begin
                    if (r_smp_cnt == SMP_TOP) begin
                        w_shift_nxt = {w_vote, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = R_STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end
                end
                R_STOP: begin
                    // Decide mid stop bit so a following start edge is seen
                    if (r_smp_cnt == C_SMP_HI) begin
                        if (w_vote) begin
                            w_data_nxt = r_shift;
                            w_flag_nxt = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                        w_state_nxt = R_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = R_IDLE;
                end
            endcase
        end

        if (w_state_nxt == R_IDLE) begin
            w_smp_cnt_nxt = 4'd0;
            w_bit_cnt_nxt = 3'd0;
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive path, 8N1, LSB first; the receive-side companion to the existing UART transmitter.
- Shares the same 16x-baud enable tick (clk_16_i) and the same system clock domain.
- Synchronizes the asynchronous serial line and detects the start edge.
- Majority-votes three mid-bit samples per bit and presents each received byte with a one-cycle valid pulse, or a frame-error pulse when the stop bit is bad.

Parameters:
- SMP_TOP, 4'd15: last oversample index in a bit period; a bit spans ticks 0..SMP_TOP.
- SMP_MID, 4'd8: centre oversample index; the vote samples are taken at SMP_MID-1, SMP_MID and SMP_MID+1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_16_i  input  1  one-clk-wide enable pulse at 16x baud rate.
- rxd_i  input  1  serial line; asynchronous to clk; idles high.
- rxd_data_o  output  8  last correctly framed byte.
- rxd_flag_o  output  1  one-clk pulse: rxd_data_o was just updated.
- frame_err_o  output  1  one-clk pulse: the stop bit sampled low.
- busy_o  output  1  high while the FSM is not in R_IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - state = R_IDLE; smp_cnt = 0; bit_cnt = 0; shift register = 0.
  - Synchronizer flops and edge-detect flop = 1.
  - rxd_data_o = 8'h00; rxd_flag_o = 0; frame_err_o = 0; busy_o = 0.
  - Reset asserted mid-frame aborts the frame immediately; no flag is issued for it.
- Synchronizer:
  - 2-flop synchronizer on rxd_i, followed by one delay flop for edge detection.
  - A falling edge is a delayed value of 1 with a synchronized value of 0.
- FSM states: R_IDLE, R_START, R_DATA, R_STOP. smp_cnt and the FSM advance only on clk cycles with clk_16_i=1; otherwise all state holds.
- R_IDLE:
  - smp_cnt = 0 and bit_cnt = 0.
  - A falling edge moves the FSM to R_START on the same clk. Edge detection does not wait for clk_16_i.
- Sampling, common to R_START, R_DATA and R_STOP:
  - smp_cnt increments on each tick and wraps SMP_TOP -> 0.
  - The synchronized line is captured on ticks where smp_cnt is SMP_MID-1, SMP_MID or SMP_MID+1.
  - The bit value is the majority of those 3 samples, available from the SMP_MID+1 tick onward.
- R_START:
  - At the SMP_MID+1 tick, a majority of 1 is a false start: go to R_IDLE with no outputs asserted.
  - Otherwise continue. At the SMP_TOP tick go to R_DATA with bit_cnt = 0.
- R_DATA:
  - At the SMP_TOP tick, shift the voted bit in at the MSB (right shift), so the first bit received ends in bit 0. Then bit_cnt++.
  - When bit_cnt == 7 at that tick, go to R_STOP instead.
- R_STOP: decided at the SMP_MID+1 tick, without waiting for the full stop bit, so back-to-back frames resynchronize.
  - Vote 1: rxd_data_o <= shift register; rxd_flag_o = 1 for exactly one clk.
  - Vote 0: frame_err_o = 1 for exactly one clk; rxd_data_o is unchanged.
  - Either way, go to R_IDLE.
- A line stuck low after a frame error does not retrigger, because a new start needs a 1 -> 0 edge.
- Latency: rxd_flag_o and frame_err_o rise on the clk edge after the decision tick.
- rxd_flag_o and frame_err_o are never high together.
- busy_o is registered and equals (state != R_IDLE).
- Width rules:
  - smp_cnt is 4 bits and wraps naturally.
  - bit_cnt is 3 bits and never exceeds 7.
  - The vote is (s0&s1) | (s1&s2) | (s0&s2).

Test Plan:
- Drive 8N1 frame 0xA5 at 16 ticks/bit (bits LSB first: 1,0,1,0,0,1,0,1) -> one rxd_flag_o pulse; rxd_data_o = 8'hA5; frame_err_o stays 0; busy_o high from edge to decision.
- Back-to-back frames 0x00 then 0xFF, stop bit exactly 16 ticks, no idle gap -> two flag pulses; data 8'h00 then 8'hFF; no frame error.
- Line low for 4 ticks then high (glitch) -> FSM returns to R_IDLE at start-bit tick SMP_MID+1; no flag, no error; next valid frame 0x3C received as 8'h3C.
- Frame 0x3C with stop bit driven 0, after a prior good byte 0x5A -> frame_err_o one-clk pulse; rxd_flag_o 0; rxd_data_o remains 8'h5A; no new frame while the line stays low.
- Frame 0x81 with data bit 0 inverted on tick SMP_MID only -> majority vote recovers; rxd_data_o = 8'h81.
- rst_n pulsed low during data bit 4 of a frame -> all outputs 0 and state R_IDLE immediately; the subsequent frame 0x7E is received correctly.
